// File: rtl/ahb_gpio_port.sv
// ahb_gpio_port: 32-bit AHB-Lite GPIO slave, zero wait states, always OKAY.
//
// Register map (byte offset, only HADDR[4:2] decoded):
//   0x00 DATA_IN  RO    synchronised pad input
//   0x04 DATA_OUT RW    drives GPIO_OUT
//   0x08 OE       RW    drives GPIO_OE
//   0x0C IE       RW    interrupt enables
//   0x10 IP       R/W1C rising-edge interrupt pending
//   0x14 OUT_SET  WO    DATA_OUT |= wdata  (GPIO_ATOMIC_SET_CLR_EN only)
//   0x18 OUT_CLR  WO    DATA_OUT &= ~wdata (GPIO_ATOMIC_SET_CLR_EN only)
//   0x1C OUT_TGL  WO    DATA_OUT ^= wdata  (GPIO_ATOMIC_SET_CLR_EN only)
//
// Ports:
//   HCLK, HRESET              clock, synchronous active-high reset
//   HSEL..HWDATA              AHB-Lite slave inputs
//   HRDATA, HREADYOUT, HRESP  AHB-Lite slave outputs
//   GPIO_OUT, GPIO_OE         pad output value / output enables
//   GPIO_IN                   pad input (asynchronous to HCLK)
//   IRQ                       level interrupt, |(IP & IE)
//
// Optional feature macro: GPIO_ATOMIC_SET_CLR_EN. When undefined, offsets
// 0x14-0x1C are unmapped (writes ignored, reads return 0).

module ahb_gpio_port (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] GPIO_OUT,
  output logic [31:0] GPIO_OE,
  input  logic [31:0] GPIO_IN,
  output logic        IRQ
);

  localparam logic [2:0] AddrDataIn  = 3'd0;
  localparam logic [2:0] AddrDataOut = 3'd1;
  localparam logic [2:0] AddrOe      = 3'd2;
  localparam logic [2:0] AddrIe      = 3'd3;
  localparam logic [2:0] AddrIp      = 3'd4;
`ifdef GPIO_ATOMIC_SET_CLR_EN
  localparam logic [2:0] AddrOutSet  = 3'd5;
  localparam logic [2:0] AddrOutClr  = 3'd6;
  localparam logic [2:0] AddrOutTgl  = 3'd7;
`endif

  // Data-phase pipeline registers.
  logic        dp_valid_q, dp_write_q;
  logic [2:0]  dp_addr_q;

  // Register file.
  logic [31:0] data_out_q, data_out_d;
  logic [31:0] oe_q, oe_d;
  logic [31:0] ie_q, ie_d;
  logic [31:0] ip_q, ip_d;

  // Input synchroniser and edge detector.
  logic [31:0] s1_q, s2_q, prev_q;
  logic [31:0] rise;

  // Counts the first three edges after reset so a pad that is already high
  // at reset release does not look like a rising edge.
  logic [1:0]  prime_cnt_q, prime_cnt_d;
  logic        prime_done;

  logic        addr_valid;
  logic        wr_en;
  logic [31:0] ip_clr;

  assign addr_valid = HSEL & HREADY & HTRANS[1] & (HSIZE == 3'b010);
  assign wr_en      = dp_valid_q & dp_write_q;
  assign rise       = s2_q & ~prev_q;
  assign prime_done = (prime_cnt_q == 2'd3);

  always_comb begin
    data_out_d = data_out_q;
    oe_d       = oe_q;
    ie_d       = ie_q;
    ip_clr     = '0;
    if (wr_en) begin
      case (dp_addr_q)
        AddrDataOut: data_out_d = HWDATA;
        AddrOe:      oe_d       = HWDATA;
        AddrIe:      ie_d       = HWDATA;
        AddrIp:      ip_clr     = HWDATA;
`ifdef GPIO_ATOMIC_SET_CLR_EN
        AddrOutSet:  data_out_d = data_out_q | HWDATA;
        AddrOutClr:  data_out_d = data_out_q & ~HWDATA;
        AddrOutTgl:  data_out_d = data_out_q ^ HWDATA;
`endif
        default: ;
      endcase
    end
    // Set after clear so a simultaneous edge wins over a W1C.
    ip_d        = (ip_q & ~ip_clr) | (prime_done ? rise : 32'h0);
    prime_cnt_d = prime_done ? prime_cnt_q : prime_cnt_q + 2'd1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_addr_q   <= '0;
      data_out_q  <= '0;
      oe_q        <= '0;
      ie_q        <= '0;
      ip_q        <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      prev_q      <= '0;
      prime_cnt_q <= '0;
    end else begin
      // Valid drops whenever no qualifying address phase is seen.
      dp_valid_q  <= addr_valid;
      dp_write_q  <= HWRITE;
      dp_addr_q   <= HADDR[4:2];
      data_out_q  <= data_out_d;
      oe_q        <= oe_d;
      ie_q        <= ie_d;
      ip_q        <= ip_d;
      s1_q        <= GPIO_IN;
      s2_q        <= s1_q;
      prev_q      <= s2_q;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  always_comb begin
    HRDATA = '0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_addr_q)
        AddrDataIn:  HRDATA = s2_q;
        AddrDataOut: HRDATA = data_out_q;
        AddrOe:      HRDATA = oe_q;
        AddrIe:      HRDATA = ie_q;
        AddrIp:      HRDATA = ip_q;
        default:     HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign GPIO_OUT  = data_out_q;
  assign GPIO_OE   = oe_q;
  assign IRQ       = |(ip_q & ie_q);

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0]};

endmodule

// File: tb/tb_ahb_gpio_port.sv
// Directed bench for ahb_gpio_port. Pads are looped back: where OE is set
// the pad follows GPIO_OUT, otherwise it follows the bench's external drive.
module tb_ahb_gpio_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel, hwrite, hready;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hrdata, gpio_out, gpio_oe, gpio_in, ext_in;
  logic        hreadyout, hresp, irq;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign gpio_in = (gpio_oe & gpio_out) | (~gpio_oe & ext_in);

  ahb_gpio_port dut (
    .HCLK      (clk),
    .HRESET    (rst),
    .HSEL      (hsel),
    .HADDR     (haddr),
    .HTRANS    (htrans),
    .HWRITE    (hwrite),
    .HSIZE     (hsize),
    .HREADY    (hready),
    .HWDATA    (hwdata),
    .HRDATA    (hrdata),
    .HREADYOUT (hreadyout),
    .HRESP     (hresp),
    .GPIO_OUT  (gpio_out),
    .GPIO_OE   (gpio_oe),
    .GPIO_IN   (gpio_in),
    .IRQ       (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'b010;
  endtask

  // One transfer: address phase, then data phase; returns HRDATA of the data phase.
  task automatic bus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                     input logic [2:0] size, output logic [31:0] rdata);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
    @(posedge clk); #1;
    idle_bus();
    hwdata = wdata;
    rdata  = hrdata;
    @(posedge clk); #1;
  endtask

  task automatic wr32(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    bus(addr, 1'b1, data, 3'b010, dummy);
  endtask

  task automatic rd32(input logic [31:0] addr, output logic [31:0] data);
    bus(addr, 1'b0, 32'h0, 3'b010, data);
  endtask

  initial begin
    rst    = 1'b1;
    hready = 1'b1;
    haddr  = '0;
    hwdata = '0;
    ext_in = '0;
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_gpio_oe", gpio_oe, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_hreadyout", {31'h0, hreadyout}, 32'h1);
    chk("rst_hresp", {31'h0, hresp}, 32'h0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // DATA_OUT write/read and pad output.
    wr32(32'h04, 32'hA5A5_0003);
    chk("gpio_out_after_wr", gpio_out, 32'hA5A5_0003);
    rd32(32'h04, rd);
    chk("rd_data_out", rd, 32'hA5A5_0003);

    // Loopback: OE[2:0] drives pads 1,1,0 from DATA_OUT; bits 0,1 rise.
    wr32(32'h08, 32'h0000_0007);
    repeat (3) @(posedge clk);
    #1;
    rd32(32'h00, rd);
    chk("rd_data_in_loop", rd, 32'h0000_0003);
    rd32(32'h08, rd);
    chk("rd_oe", rd, 32'h0000_0007);
    rd32(32'h10, rd);
    chk("ip_from_loopback", rd, 32'h0000_0003);
    chk("irq_ie0", {31'h0, irq}, 32'h0);
    wr32(32'h10, 32'hFFFF_FFFF);
    rd32(32'h10, rd);
    chk("ip_cleared_all", rd, 32'h0);

    // Rising edge on bit 0 with IE[0]=1: IP sets on edge N+2.
    wr32(32'h08, 32'h0);
    wr32(32'h0C, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("irq_before_edge", {31'h0, irq}, 32'h0);
    ext_in[0] = 1'b1;
    @(posedge clk); #1;  // edge N
    @(posedge clk); #1;  // edge N+1
    chk("irq_edge_n1", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;  // edge N+2
    chk("irq_edge_n2", {31'h0, irq}, 32'h1);
    rd32(32'h10, rd);
    chk("ip_bit0", rd, 32'h1);
    wr32(32'h10, 32'h1);
    chk("irq_after_w1c", {31'h0, irq}, 32'h0);
    rd32(32'h10, rd);
    chk("ip_after_w1c", rd, 32'h0);

    // Bit 5 rise lands on the same edge as a W1C of bit 5: set wins.
    ext_in[5] = 1'b1;
    @(posedge clk); #1;  // edge N
    wr32(32'h10, 32'h20);  // address N+1, commit N+2
    rd32(32'h10, rd);
    chk("ip5_set_wins", rd, 32'h20);
    wr32(32'h10, 32'h0);
    rd32(32'h10, rd);
    chk("ip_w0_nochange", rd, 32'h20);
    wr32(32'h10, 32'h20);
    rd32(32'h10, rd);
    chk("ip5_cleared", rd, 32'h0);

    // Atomic output registers.
    wr32(32'h04, 32'h0000_00F0);
    wr32(32'h14, 32'h0F);
    rd32(32'h04, rd);
`ifdef GPIO_ATOMIC_SET_CLR_EN
    chk("out_set", rd, 32'hFF);
`else
    chk("out_set_unmapped", rd, 32'hF0);
`endif
    wr32(32'h18, 32'h30);
    rd32(32'h04, rd);
`ifdef GPIO_ATOMIC_SET_CLR_EN
    chk("out_clr", rd, 32'hCF);
`else
    chk("out_clr_unmapped", rd, 32'hF0);
`endif
    wr32(32'h1C, 32'h81);
    rd32(32'h04, rd);
`ifdef GPIO_ATOMIC_SET_CLR_EN
    chk("out_tgl", rd, 32'h4E);
`else
    chk("out_tgl_unmapped", rd, 32'hF0);
`endif
    rd32(32'h14, rd);
    chk("rd_set_zero", rd, 32'h0);
    rd32(32'h18, rd);
    chk("rd_clr_zero", rd, 32'h0);
    rd32(32'h1C, rd);
    chk("rd_tgl_zero", rd, 32'h0);

    // Non-word transfers are ignored and read 0; DATA_IN writes ignored.
    bus(32'h04, 1'b1, 32'h1234_5678, 3'b000, rd);
    bus(32'h04, 1'b0, 32'h0, 3'b001, rd);
    chk("rd_byte_zero", rd, 32'h0);
    rd32(32'h04, rd);
    chk("byte_wr_ignored", rd, gpio_out);
    chk("data_out_unchanged", gpio_out,
`ifdef GPIO_ATOMIC_SET_CLR_EN
        32'h4E
`else
        32'hF0
`endif
    );
    wr32(32'h00, 32'hFFFF_FFFF);
    rd32(32'h00, rd);
    chk("data_in_ro", rd, 32'h0000_0021);

    // Back-to-back write then read of IE.
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0C; hwrite = 1'b1; hsize = 3'b010;
    @(posedge clk); #1;
    hwdata = 32'h0000_005A; hwrite = 1'b0; htrans = 2'b11;
    @(posedge clk); #1;
    idle_bus();
    chk("pipelined_rd", hrdata, 32'h0000_005A);
    @(posedge clk); #1;

    // Reset lands in the data phase of an OE write.
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h08; hwrite = 1'b1; hsize = 3'b010;
    @(posedge clk); #1;
    idle_bus();
    hwdata = 32'hFFFF_FFFF;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_dp_oe", gpio_oe, 32'h0);
    chk("rst_dp_out", gpio_out, 32'h0);
    chk("rst_dp_irq", {31'h0, irq}, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    rd32(32'h08, rd);
    chk("rst_dp_rd_oe", rd, 32'h0);
    rd32(32'h0C, rd);
    chk("rst_dp_rd_ie", rd, 32'h0);
    // Pads 0 and 5 were already high at reset release: no IP.
    rd32(32'h10, rd);
    chk("rst_prime_ip", rd, 32'h0);
    rd32(32'h00, rd);
    chk("rst_data_in", rd, 32'h0000_0021);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_gpio_port.md
AHB_GPIO_PORT -- requirements
Module: ahb_gpio_port

Interface
REQ-001 HCLK  input  1  sole clock; all state updates on its rising edge.
REQ-002 HRESET  input  1  reset, synchronous, active-high.
REQ-003 HSEL  input  1  slave select.
REQ-004 HADDR  input  32  address; only HADDR[4:2] decoded.
REQ-005 HTRANS  input  2  transfer type; NONSEQ (2) or SEQ (3) is a valid transfer.
REQ-006 HWRITE  input  1  1 = write.
REQ-007 HSIZE  input  3  transfer size; only 3'b010 (word) is accepted.
REQ-008 HREADY  input  1  bus ready; an address phase is taken only when high.
REQ-009 HWDATA  input  32  write data, valid in the data phase.
REQ-010 HRDATA  output  32  read data, valid in the data phase.
REQ-011 HREADYOUT  output  1  constant 1 (zero wait states).
REQ-012 HRESP  output  1  constant 0 (OKAY).
REQ-013 GPIO_OUT  output  32  pad output value (DATA_OUT register).
REQ-014 GPIO_OE  output  32  pad output enables (OE register).
REQ-015 GPIO_IN  input  32  pad input, asynchronous to HCLK.
REQ-016 IRQ  output  1  level interrupt, equal to |(IP & IE).

Function
REQ-017 Address phase valid = HSEL & HREADY & HTRANS[1] & (HSIZE==3'b010); capture HWRITE and HADDR[4:2] into data-phase registers on that edge.
REQ-018 Valid is cleared when no qualifying address phase occurs, so a pending data phase never repeats.
REQ-019 Register map (byte offset): 0x00 DATA_IN RO; 0x04 DATA_OUT RW; 0x08 OE RW; 0x0C IE RW; 0x10 IP R/W1C; 0x14 OUT_SET WO; 0x18 OUT_CLR WO; 0x1C OUT_TGL WO.
REQ-020 A write commits on the HCLK edge that ends its data phase, using HWDATA sampled on that edge.
REQ-021 HRDATA is combinational from the registered data-phase address and the current register contents.
- Reads of write-only offsets, or any read with no valid data phase, return 0.
REQ-022 Writes to DATA_IN are ignored; non-word transfers are ignored and read 0; all transfers complete with OKAY.
REQ-023 GPIO_IN passes through a 2-flop synchronizer (s1, s2); DATA_IN = s2.
- A pad change sampled on edge N is readable after edge N+1.
REQ-024 Rising-edge detection: rise = s2 & ~prev, where prev <= s2 every cycle.
- IP[i] sets on edge N+2 for an input change sampled on edge N, independent of IE.
REQ-025 IP bits cannot set during the first 3 HCLK edges after reset release (synchronizer priming window).
REQ-026 IP write: each bit written 1 clears that IP bit; each bit written 0 leaves it unchanged.
- When a set and a clear hit the same bit on the same edge, the set wins.
REQ-027 IRQ is combinational from registered IP and IE, with no extra latency.
REQ-028 Writes to IE take effect on IRQ the cycle after the commit edge; IE does not gate IP capture.

Reset
REQ-029 While HRESET is high on an edge, the following clear to 0: DATA_OUT, OE, IE, IP, s1, s2, prev, the data-phase valid/write/address registers, and the priming counter.
REQ-030 During and right after reset: GPIO_OUT=0, GPIO_OE=0, IRQ=0, HRDATA=0, HREADYOUT=1, HRESP=0.
REQ-031 Reset asserted during a data phase discards the pending write and changes no register.

Configuration
REQ-032 Macro GPIO_ATOMIC_SET_CLR_EN controls the atomic output registers.
- Defined: OUT_SET does DATA_OUT |= HWDATA; OUT_CLR does DATA_OUT &= ~HWDATA; OUT_TGL does DATA_OUT ^= HWDATA; each commits in one edge.
- Not defined: offsets 0x14-0x1C are unmapped; writes are ignored and reads return 0.

Verification
REQ-033 Write 0x04=0xA5A5_0003, then read 0x04 -> HRDATA=0xA5A5_0003, and GPIO_OUT=0xA5A5_0003 from the edge after the data phase.
REQ-034 Write OE=0x0000_0007; GPIO_IN driven by a tri-state loopback (pad = OE ? OUT : Z); read 0x00 -> bits[2:0] equal DATA_OUT[2:0].
REQ-035 GPIO_IN[0] goes 0->1 at edge N with IE=1 -> IP[0]=1 and IRQ=1 after edge N+2; write 0x10=0x1 -> IP=0 and IRQ=0.
REQ-036 Rising edge on bit 5 on the same edge as a W1C write of bit 5 -> IP[5] remains 1.
REQ-037 With macro defined, DATA_OUT=0xF0: SET 0x0F, then CLR 0x30, then TGL 0x81 -> DATA_OUT reads 0xFF, 0xCF, 0x4E; without the macro, DATA_OUT stays 0xF0 and offsets 0x14-0x1C read 0.
REQ-038 Write issued, HRESET asserted in its data phase -> all registers remain 0 and GPIO_OE=0; back-to-back write-then-read pipelined transfers return the new value with no wait states.
